mem_1r1w_masked_rmw_32x64: RTL and testbench
============================================

MEM_1R1W_MASKED_RMW_32X64 -- requirements
Module: mem_1r1w_masked_rmw_32x64

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of words.
REQ-002 SHALL have parameter WIDTH, default 64, data bits per word.
REQ-003 SHALL have parameter MASK_GRAN, default 8, bits per mask lane; lanes = WIDTH/MASK_GRAN.
REQ-004 SHALL have port clock  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports R0_addr in 5, R0_en in 1, R0_ready out 1 (read accepted this cycle), R0_data out 64.
REQ-007 SHALL have ports W0_addr in 5, W0_en in 1 (valid), W0_data in 64, W0_mask in 8, W0_ready out 1.
REQ-008 SHALL have macro-side ports AA out 5, CENA out 1 (active-low), QA in 64, AB out 5, CENB out 1 (active-low), DB out 64, for an unmasked 1r1w macro with 1-cycle read latency.

Function
REQ-009 SHALL emulate byte-masked writes by read-modify-write on the unmasked macro.
REQ-010 SHALL implement FSM states IDLE, RD, WR.
REQ-011 IDLE: W0_ready=1; W0_en&&W0_ready latches addr/data/mask, goes to RD.
REQ-012 RD: CENA=0, AA=latched addr, R0_ready=0, W0_ready=0; always goes to WR.
REQ-013 WR: CENB=0, AB=latched addr, DB lane i = mask[i] ? latched data lane i : QA lane i; W0_ready=0; goes to IDLE.
REQ-014 Masked write SHALL be visible in the macro from the cycle after WR; throughput one write per 3 cycles.
REQ-015 R0_ready SHALL be 1 in IDLE and WR, 0 in RD and during reset.
REQ-016 Accepted read drives CENA=0, AA=R0_addr; R0_data valid exactly the cycle after acceptance, else undefined.
REQ-017 Read accepted in WR with R0_addr==latched addr SHALL return merged DB value next cycle via bypass register, not QA.
REQ-018 Read accepted in IDLE in same cycle as a write is accepted SHALL return pre-write data.
REQ-019 Write with W0_mask==0 SHALL still traverse RD/WR and rewrite unchanged data.
REQ-020 Idle outputs: CENA=1, CENB=1, AA=0, AB=0, DB=0.

Reset
REQ-021 On reset: state=IDLE, W0_ready=0, R0_ready=0, CENA=1, CENB=1, AA=AB=DB=0, bypass select cleared.
REQ-022 Reset during RD or WR SHALL discard the pending write; macro SHALL NOT be written in the reset cycle.
REQ-023 W0_ready SHALL rise in the first cycle after reset deasserts.

Configuration
REQ-024 Macro MEM_RMW_FULLMASK_BYPASS_EN defined: write accepted in IDLE with W0_mask all-ones SHALL write the macro directly in the acceptance cycle (CENB=0, AB=W0_addr, DB=W0_data), state stays IDLE, W0_ready stays 1.
REQ-025 Macro undefined: all-ones mask writes SHALL follow IDLE->RD->WR like any other.
REQ-026 With bypass, same-cycle read of the same address SHALL return pre-write data.

Structure
REQ-027 Shared package mem_lower_pkg SHALL hold FSM state enum, ADDR_W=5, LANES=8 and a lane-merge function.
REQ-028 Lane merge SHALL be a sub-module mem_mask_merge (data, old, mask -> merged), combinational.
REQ-029 Macro behavioural model SHALL live only in the bench.

Verification
REQ-030 Preload addr 3 = 0x1111_2222_3333_4444; write addr 3, data 0xAAAA..., mask 0x0F -> macro word 0x1111_2222_AAAA_AAAA (WR cycle DB).
REQ-031 Write accepted cycle 0 -> CENA=0 cycle 1, CENB=0 cycle 2, W0_ready high cycle 3; R0_ready=0 cycle 1 only.
REQ-032 Read addr 3 accepted in WR of REQ-030 write -> R0_data next cycle = 0x1111_2222_AAAA_AAAA.
REQ-033 Reset asserted in RD of a write to addr 7 -> CENB never low, addr 7 unchanged, W0_ready=1 after release.
REQ-034 MEM_RMW_FULLMASK_BYPASS_EN: back-to-back mask 0xFF writes to addrs 0..3 -> four CENB pulses in four consecutive cycles, W0_ready constant 1; undefined: 12 cycles.
REQ-035 Continuous reads with one pending write -> write completes in 3 cycles; exactly one read cycle refused.

Source files
------------

// File: rtl/mem_lower_pkg.sv
// Shared definitions for the masked read-modify-write memory wrapper.
//   state_e    : RMW sequencer states (IDLE -> RD -> WR -> IDLE)
//   ADDR_W     : macro address width
//   LANES      : mask lanes per word at the default geometry
//   lane_merge : reference lane merge at the default geometry (64b, 8b lanes)
package mem_lower_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  localparam int ADDR_W = 5;
  localparam int LANES  = 8;
  localparam int LANE_W = 8;

  function automatic logic [LANES*LANE_W-1:0] lane_merge(
    input logic [LANES*LANE_W-1:0] data,
    input logic [LANES*LANE_W-1:0] old,
    input logic [LANES-1:0]        mask
  );
    logic [LANES*LANE_W-1:0] r;
    r = old;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) r[i*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_mask_merge.sv
// Combinational lane merge: each MASK_GRAN-bit lane of merged takes the new
// data where its mask bit is set, otherwise keeps the old word's lane.
//   data   : new write data
//   old    : current word read from the macro
//   mask   : one bit per lane
//   merged : word to write back
module mem_mask_merge #(
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 8
) (
  input  logic [WIDTH-1:0]           data,
  input  logic [WIDTH-1:0]           old,
  input  logic [WIDTH/MASK_GRAN-1:0] mask,
  output logic [WIDTH-1:0]           merged
);

  localparam int NL = WIDTH / MASK_GRAN;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    assign merged[i*MASK_GRAN +: MASK_GRAN] = mask[i] ? data[i*MASK_GRAN +: MASK_GRAN]
                                                      : old[i*MASK_GRAN +: MASK_GRAN];
  end

endmodule

// File: rtl/mem_1r1w_masked_rmw_32x64.sv
// Masked-write 1R1W memory built on an unmasked 1R1W macro (1-cycle read
// latency). Masked writes run read-modify-write: IDLE accepts, RD reads the
// old word on port A, WR writes the merged word on port B.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   R0_addr/en/ready/data : read port; data valid the cycle after acceptance
//   W0_addr/en/data/mask  : masked write port, W0_ready = accept
//   AA/CENA/QA            : macro read port (CENA active low)
//   AB/CENB/DB            : macro write port (CENB active low)
// Optional feature: define MEM_RMW_FULLMASK_BYPASS_EN to write all-ones-mask
// writes straight into the macro in the acceptance cycle.
module mem_1r1w_masked_rmw_32x64
  import mem_lower_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          R0_addr,
  input  logic                       R0_en,
  output logic                       R0_ready,
  output logic [WIDTH-1:0]           R0_data,
  input  logic [ADDR_W-1:0]          W0_addr,
  input  logic                       W0_en,
  input  logic [WIDTH-1:0]           W0_data,
  input  logic [WIDTH/MASK_GRAN-1:0] W0_mask,
  output logic                       W0_ready,
  output logic [ADDR_W-1:0]          AA,
  output logic                       CENA,
  input  logic [WIDTH-1:0]           QA,
  output logic [ADDR_W-1:0]          AB,
  output logic                       CENB,
  output logic [WIDTH-1:0]           DB
);

  localparam int NL = WIDTH / MASK_GRAN;

  if (DEPTH > (1 << ADDR_W)) begin : g_depth_chk
    $error("DEPTH does not fit in ADDR_W address bits");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [NL-1:0]     mask_q, mask_d;
  logic              byp_sel_q, byp_sel_d;
  logic [WIDTH-1:0]  byp_data_q, byp_data_d;
  logic [WIDTH-1:0]  merged;
  logic              rd_acc;

  // QA holds the word fetched in RD throughout the WR cycle.
  mem_mask_merge #(.WIDTH(WIDTH), .MASK_GRAN(MASK_GRAN)) u_merge (
    .data   (data_q),
    .old    (QA),
    .mask   (mask_q),
    .merged (merged)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    byp_sel_d  = 1'b0;
    byp_data_d = byp_data_q;
    CENA       = 1'b1;
    AA         = '0;
    CENB       = 1'b1;
    AB         = '0;
    DB         = '0;
    R0_ready   = 1'b0;
    W0_ready   = 1'b0;
    rd_acc     = 1'b0;
    // Everything is held idle while reset is high so a write caught
    // mid-sequence never reaches the macro.
    if (!reset) begin
      R0_ready = (state_q != ST_RD);
      W0_ready = (state_q == ST_IDLE);
      rd_acc   = R0_en && R0_ready;
      if (rd_acc) begin
        CENA = 1'b0;
        AA   = R0_addr;
      end
      case (state_q)
        ST_IDLE: begin
          if (W0_en) begin
`ifdef MEM_RMW_FULLMASK_BYPASS_EN
            if (&W0_mask) begin
              CENB = 1'b0;
              AB   = W0_addr;
              DB   = W0_data;
            end else begin
              addr_d  = W0_addr;
              data_d  = W0_data;
              mask_d  = W0_mask;
              state_d = ST_RD;
            end
`else
            addr_d  = W0_addr;
            data_d  = W0_data;
            mask_d  = W0_mask;
            state_d = ST_RD;
`endif
          end
        end
        ST_RD: begin
          CENA    = 1'b0;
          AA      = addr_q;
          state_d = ST_WR;
        end
        ST_WR: begin
          CENB    = 1'b0;
          AB      = addr_q;
          DB      = merged;
          state_d = ST_IDLE;
          // Port A would return the stale word next cycle; forward the merge.
          if (rd_acc && (R0_addr == addr_q)) begin
            byp_sel_d  = 1'b1;
            byp_data_d = merged;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      byp_sel_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      byp_sel_q  <= byp_sel_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign R0_data = byp_sel_q ? byp_data_q : QA;

endmodule

// File: tb/tb_mem_1r1w_masked_rmw_32x64.sv
module tb_mem_1r1w_masked_rmw_32x64;

`ifdef MEM_RMW_FULLMASK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  R0_addr = '0, W0_addr = '0, AA, AB;
  logic        R0_en = 1'b0, W0_en = 1'b0, R0_ready, W0_ready, CENA, CENB;
  logic [63:0] R0_data, W0_data = '0, QA = '0, DB;
  logic [7:0]  W0_mask = '0;

  logic [63:0] mem [0:31];
  logic [63:0] ref_mem [0:31];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [63:0] pl_data = '0;
  int          wr_cnt = 0;
  int          total = 0, bad = 0;

  always #5 clock = ~clock;

  mem_1r1w_masked_rmw_32x64 dut (
    .clock(clock), .reset(reset),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_ready(R0_ready), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask), .W0_ready(W0_ready),
    .AA(AA), .CENA(CENA), .QA(QA), .AB(AB), .CENB(CENB), .DB(DB)
  );

  // Unmasked 1R1W macro: registered read, read-before-write on collision.
  always @(posedge clock) begin
    if (!CENA) QA <= mem[AA];
    if (!CENB) begin
      mem[AB] <= DB;
      wr_cnt  <= wr_cnt + 1;
    end
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = m[i] ? d[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    R0_en = 1'b0; W0_en = 1'b0;
  endtask

  task automatic test_reset();
    R0_en = 1'b1; W0_en = 1'b1; W0_mask = 8'hFF; R0_addr = 5'd4; W0_addr = 5'd9; W0_data = '1;
    repeat (2) @(negedge clock);
    #1;
    total += 7;
    if (W0_ready !== 1'b0) begin bad++; $display("FAIL rst_w0_ready got=%b exp=0", W0_ready); end
    if (R0_ready !== 1'b0) begin bad++; $display("FAIL rst_r0_ready got=%b exp=0", R0_ready); end
    if (CENA !== 1'b1)     begin bad++; $display("FAIL rst_cena got=%b exp=1", CENA); end
    if (CENB !== 1'b1)     begin bad++; $display("FAIL rst_cenb got=%b exp=1", CENB); end
    if (AA !== 5'd0)       begin bad++; $display("FAIL rst_aa got=%h exp=0", AA); end
    if (AB !== 5'd0)       begin bad++; $display("FAIL rst_ab got=%h exp=0", AB); end
    if (DB !== 64'd0)      begin bad++; $display("FAIL rst_db got=%h exp=0", DB); end
    idle_inputs();
    // Preload the macro while still in reset.
    for (int a = 0; a < 32; a++) begin
      @(negedge clock);
      pl_en = 1'b1; pl_addr = 5'(a);
      pl_data = (a == 3) ? 64'h1111_2222_3333_4444 : {$urandom, $urandom};
      ref_mem[a] = pl_data;
    end
    @(negedge clock);
    pl_en = 1'b0;
    total++;
    if (wr_cnt != 0) begin bad++; $display("FAIL rst_no_write got=%0d exp=0", wr_cnt); end
    reset = 1'b0;
    #1;
    total++;
    if (W0_ready !== 1'b1) begin bad++; $display("FAIL rst_release_w0_ready got=%b exp=1", W0_ready); end
  endtask

  task automatic test_rmw_directed();
    logic [63:0] exp_w;
    exp_w = 64'h1111_2222_AAAA_AAAA;
    @(negedge clock);
    W0_en = 1'b1; W0_addr = 5'd3; W0_data = 64'hAAAA_AAAA_AAAA_AAAA; W0_mask = 8'h0F; R0_en = 1'b0;
    #1;
    total++;
    if (W0_ready !== 1'b1) begin bad++; $display("FAIL rmw_c0_w0_ready got=%b exp=1", W0_ready); end
    @(negedge clock);
    W0_en = 1'b0;
    #1;
    total += 5;
    if (CENA !== 1'b0)     begin bad++; $display("FAIL rmw_c1_cena got=%b exp=0", CENA); end
    if (AA !== 5'd3)       begin bad++; $display("FAIL rmw_c1_aa got=%h exp=3", AA); end
    if (CENB !== 1'b1)     begin bad++; $display("FAIL rmw_c1_cenb got=%b exp=1", CENB); end
    if (R0_ready !== 1'b0) begin bad++; $display("FAIL rmw_c1_r0_ready got=%b exp=0", R0_ready); end
    if (W0_ready !== 1'b0) begin bad++; $display("FAIL rmw_c1_w0_ready got=%b exp=0", W0_ready); end
    @(negedge clock);
    R0_en = 1'b1; R0_addr = 5'd3;
    #1;
    total += 5;
    if (CENB !== 1'b0)     begin bad++; $display("FAIL rmw_c2_cenb got=%b exp=0", CENB); end
    if (AB !== 5'd3)       begin bad++; $display("FAIL rmw_c2_ab got=%h exp=3", AB); end
    if (DB !== exp_w)      begin bad++; $display("FAIL rmw_c2_db got=%h exp=%h", DB, exp_w); end
    if (R0_ready !== 1'b1) begin bad++; $display("FAIL rmw_c2_r0_ready got=%b exp=1", R0_ready); end
    if (W0_ready !== 1'b0) begin bad++; $display("FAIL rmw_c2_w0_ready got=%b exp=0", W0_ready); end
    @(negedge clock);
    R0_en = 1'b0;
    #1;
    total += 4;
    if (R0_data !== exp_w) begin bad++; $display("FAIL rmw_bypass_rdata got=%h exp=%h", R0_data, exp_w); end
    if (W0_ready !== 1'b1) begin bad++; $display("FAIL rmw_c3_w0_ready got=%b exp=1", W0_ready); end
    if (CENB !== 1'b1)     begin bad++; $display("FAIL rmw_c3_cenb got=%b exp=1", CENB); end
    if (mem[3] !== exp_w)  begin bad++; $display("FAIL rmw_macro_word got=%h exp=%h", mem[3], exp_w); end
    ref_mem[3] = exp_w;
  endtask

  task automatic test_reset_mid();
    logic [63:0] old7;
    int          w0;
    old7 = ref_mem[7];
    w0 = wr_cnt;
    @(negedge clock);
    W0_en = 1'b1; W0_addr = 5'd7; W0_data = ~old7; W0_mask = 8'h5A;
    @(negedge clock);
    W0_en = 1'b0; reset = 1'b1;
    #1;
    total += 2;
    if (CENB !== 1'b1) begin bad++; $display("FAIL rstmid_cenb got=%b exp=1", CENB); end
    if (CENA !== 1'b1) begin bad++; $display("FAIL rstmid_cena got=%b exp=1", CENA); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if (W0_ready !== 1'b1) begin bad++; $display("FAIL rstmid_w0_ready got=%b exp=1", W0_ready); end
    repeat (4) @(negedge clock);
    total += 2;
    if (wr_cnt != w0)     begin bad++; $display("FAIL rstmid_writes got=%0d exp=%0d", wr_cnt - w0, 0); end
    if (mem[7] !== old7)  begin bad++; $display("FAIL rstmid_word got=%h exp=%h", mem[7], old7); end
  endtask

  task automatic test_same_cycle_read();
    logic [63:0] old5, nw;
    old5 = ref_mem[5];
    nw = {$urandom, $urandom};
    @(negedge clock);
    W0_en = 1'b1; W0_addr = 5'd5; W0_data = nw; W0_mask = 8'hFF;
    R0_en = 1'b1; R0_addr = 5'd5;
    #1;
    total++;
    if (W0_ready !== 1'b1) begin bad++; $display("FAIL same_w0_ready got=%b exp=1", W0_ready); end
    @(negedge clock);
    idle_inputs();
    #1;
    total++;
    if (R0_data !== old5) begin bad++; $display("FAIL same_cycle_rdata got=%h exp=%h", R0_data, old5); end
    repeat (3) @(negedge clock);
    ref_mem[5] = nw;
    total++;
    if (mem[5] !== nw) begin bad++; $display("FAIL same_word got=%h exp=%h", mem[5], nw); end
  endtask

  task automatic test_fullmask_b2b();
    logic [63:0] d [4];
    int idx = 0, pulses = 0, first_acc = -1, last_w = -1, dropped = 0, span;
    for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
    for (int c = 0; c < 40 && pulses < 4; c++) begin
      @(negedge clock);
      if (idx < 4) begin
        W0_en = 1'b1; W0_addr = 5'(idx); W0_data = d[idx]; W0_mask = 8'hFF;
      end else W0_en = 1'b0;
      #1;
      if (!W0_ready) dropped = 1;
      if (!CENB) begin pulses++; last_w = c; end
      if (W0_en && W0_ready) begin
        if (first_acc < 0) first_acc = c;
        idx++;
      end
    end
    idle_inputs();
    span = last_w - first_acc + 1;
    total += 3;
    if (pulses != 4) begin bad++; $display("FAIL b2b_pulses got=%0d exp=4", pulses); end
    if (span != (BYP ? 4 : 12)) begin bad++; $display("FAIL b2b_cycles got=%0d exp=%0d", span, BYP ? 4 : 12); end
    if (dropped != (BYP ? 0 : 1)) begin bad++; $display("FAIL b2b_w0_ready_drop got=%0d exp=%0d", dropped, BYP ? 0 : 1); end
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      ref_mem[i] = d[i];
      total++;
      if (mem[i] !== d[i]) begin bad++; $display("FAIL b2b_word%0d got=%h exp=%h", i, mem[i], d[i]); end
    end
  endtask

  task automatic test_reads_with_write();
    logic [63:0] nw;
    int refused = 0, back = -1;
    nw = {$urandom, $urandom};
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      R0_en = 1'b1; R0_addr = 5'($urandom_range(10, 31));
      W0_en = (k == 0); W0_addr = 5'd9; W0_data = nw; W0_mask = 8'h3C;
      #1;
      if (!R0_ready) refused++;
      if (k > 0 && W0_ready && back < 0) back = k;
    end
    idle_inputs();
    ref_mem[9] = merge(ref_mem[9], nw, 8'h3C);
    @(negedge clock);
    total += 3;
    if (refused != 1) begin bad++; $display("FAIL rdw_refused got=%0d exp=1", refused); end
    if (back != 3)    begin bad++; $display("FAIL rdw_ready_back got=%0d exp=3", back); end
    if (mem[9] !== ref_mem[9]) begin bad++; $display("FAIL rdw_word got=%h exp=%h", mem[9], ref_mem[9]); end
  endtask

  // Reference: a write accepted at cycle t is seen by reads from t+2 (RMW,
  // via WR-cycle forwarding) or t+1 (full-mask bypass) and frees the write
  // port at t+3 / t+1; the read port refuses only at t+1 of an RMW.
  task automatic test_random();
    logic [63:0] exp_rd = '0, pd = '0;
    logic [4:0]  pa = '0;
    logic [7:0]  pm = '0;
    bit rd_prev = 0, pv = 0, prmw = 0, w_exp, r_exp;
    int pt = 0, pvis = 0, pdone = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (rd_prev) begin
        total++;
        if (R0_data !== exp_rd) begin bad++; $display("FAIL rand_rdata k=%0d got=%h exp=%h", k, R0_data, exp_rd); end
      end
      if (pv && k >= pdone) begin ref_mem[pa] = merge(ref_mem[pa], pd, pm); pv = 0; end
      R0_en = 1'($urandom_range(0, 1)); R0_addr = 5'($urandom_range(0, 7));
      W0_en = ($urandom_range(0, 2) == 0); W0_addr = 5'($urandom_range(0, 7));
      W0_data = {$urandom, $urandom};
      W0_mask = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      #1;
      w_exp = !pv;
      r_exp = !(pv && prmw && k == pt + 1);
      total += 2;
      if (W0_ready !== w_exp) begin bad++; $display("FAIL rand_w0_ready k=%0d got=%b exp=%b", k, W0_ready, w_exp); end
      if (R0_ready !== r_exp) begin bad++; $display("FAIL rand_r0_ready k=%0d got=%b exp=%b", k, R0_ready, r_exp); end
      rd_prev = R0_en && r_exp;
      if (rd_prev)
        exp_rd = (pv && k >= pvis && R0_addr == pa) ? merge(ref_mem[pa], pd, pm) : ref_mem[R0_addr];
      if (W0_en && w_exp) begin
        pv = 1; pt = k; pa = W0_addr; pd = W0_data; pm = W0_mask;
        prmw  = !(BYP && W0_mask == 8'hFF);
        pvis  = prmw ? k + 2 : k + 1;
        pdone = prmw ? k + 3 : k + 1;
      end
    end
    @(negedge clock);
    idle_inputs();
    if (rd_prev) begin
      total++;
      if (R0_data !== exp_rd) begin bad++; $display("FAIL rand_rdata_last got=%h exp=%h", R0_data, exp_rd); end
    end
    repeat (4) @(negedge clock);
    if (pv) ref_mem[pa] = merge(ref_mem[pa], pd, pm);
    for (int a = 0; a < 32; a++) begin
      total++;
      if (mem[a] !== ref_mem[a]) begin bad++; $display("FAIL rand_final_word%0d got=%h exp=%h", a, mem[a], ref_mem[a]); end
    end
  endtask

  initial begin
    test_reset();
    test_rmw_directed();
    test_reset_mid();
    test_same_cycle_read();
    test_fullmask_b2b();
    test_reads_with_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
